// File: rtl/event_assign_sched_if.sv
// Bundle of request/response signals between the stimulus agents and the
// deferred-assignment scheduler.
//   master : agents side   (drives req/req_delay/req_value/cancel)
//   slave  : scheduler side (drives grant/busy/event_fire/value_out/value_valid)
interface event_assign_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int DLYW = 4
);
  logic [NREQ-1:0]      req;
  logic [NREQ*DLYW-1:0] req_delay;
  logic [NREQ*DW-1:0]   req_value;
  logic                 cancel;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 event_fire;
  logic [DW-1:0]        value_out;
  logic                 value_valid;

  modport master (
    output req, req_delay, req_value, cancel,
    input  grant, busy, event_fire, value_out, value_valid
  );

  modport slave (
    input  req, req_delay, req_value, cancel,
    output grant, busy, event_fire, value_out, value_valid
  );
endinterface

// File: rtl/event_assign_sched.sv
// Round-robin scheduler for a shared deferred-assignment target
// ("target = @event value"). One requester is granted, its value is captured
// at grant time, its delay is counted down, then a one-cycle event fires and
// the captured value is committed to the shared target register.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of event_assign_sched_if
//             in : req, req_delay, req_value, cancel
//             out: grant (one-hot pulse), busy, event_fire (pulse),
//                  value_out (target register), value_valid (sticky)
module event_assign_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int DLYW = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  event_assign_sched_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    FIRE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            fire_q, fire_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   value_q, value_d;
  logic [DW-1:0]   cap_q, cap_d;
  logic [DLYW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   last_q, last_d;

  logic            sel_found;
  logic [PW-1:0]   sel_idx;

  // Index reached by stepping 'off' positions past the round-robin pointer.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NREQ;
    return s[PW-1:0];
  endfunction

  // First asserted request scanning last+1, last+2, ... (wrapping); the
  // pointer itself is scanned last so the previous winner has lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!sel_found && bus.req[rr_index(last_q, off)]) begin
        sel_found = 1'b1;
        sel_idx   = rr_index(last_q, off);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    fire_d  = 1'b0;
    value_d = value_q;
    valid_d = valid_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
          cap_d   = bus.req_value[sel_idx*DW +: DW];
          cnt_d   = bus.req_delay[sel_idx*DLYW +: DLYW];
          last_d  = sel_idx;
          state_d = ARM;
        end
      end
      ARM: begin
        // Cancel wins even on the cycle the count would expire.
        if (bus.cancel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = FIRE;
          fire_d  = 1'b1;
          value_d = cap_q;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIRE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      fire_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      last_q  <= PW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      fire_q  <= fire_d;
      valid_q <= valid_d;
      value_q <= value_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.event_fire  = fire_q;
  assign bus.value_out   = value_q;
  assign bus.value_valid = valid_q;

endmodule

// File: tb/tb_event_assign_sched.sv
module tb_event_assign_sched;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int DLYW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  event_assign_sched_if #(.NREQ(NREQ), .DW(DW), .DLYW(DLYW)) bus();

  event_assign_sched #(.NREQ(NREQ), .DW(DW), .DLYW(DLYW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [NREQ-1:0]      req;
    logic [NREQ*DLYW-1:0] dly;
    logic [NREQ*DW-1:0]   val;
    logic                 cancel;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 fire;
    logic [DW-1:0]        vout;
    logic                 valid;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [NREQ-1:0] g, input logic b,
                            input logic f, input logic [DW-1:0] v, input logic vv);
    check({tag, ".grant"},       32'(bus.grant),       32'(g));
    check({tag, ".busy"},        32'(bus.busy),        32'(b));
    check({tag, ".event_fire"},  32'(bus.event_fire),  32'(f));
    check({tag, ".value_out"},   32'(bus.value_out),   32'(v));
    check({tag, ".value_valid"}, 32'(bus.value_valid), 32'(vv));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit
  // after the following rising edge.
  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ*DLYW-1:0] d,
                       input logic [NREQ*DW-1:0] v, input logic c);
    @(negedge clk);
    bus.req = r; bus.req_delay = d; bus.req_value = v; bus.cancel = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = '0; bus.req_delay = '0; bus.req_value = '0; bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference model state (timeline view: which cycle fires, from which
  // cycle the scheduler can accept again).
  int              m_last, m_fire_at, m_idle_from, m_sel;
  bit              m_armed, m_found;
  logic [DW-1:0]   m_cap, m_val;
  bit              m_valid;
  logic [NREQ-1:0] e_grant;
  bit              e_fire;
  logic [NREQ-1:0]      r_req;
  logic [NREQ*DLYW-1:0] r_dly;
  logic [NREQ*DW-1:0]   r_val;
  logic                 r_can;
  int              rr_order[$];
  int              rr_time[$];
  int              exp_order[5] = '{0, 1, 2, 3, 0};
  logic [NREQ-1:0] mask;
  int              fire_seen, steps;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{4'b0010, 16'h0040, 16'h0050, 1'b0, 4'b0010, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = tbl[1];
    tbl[5]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b1, 4'h5, 1'b1};
    tbl[6]  = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h5, 1'b1};
    tbl[7]  = '{4'b0001, 16'h0000, 16'h000A, 1'b0, 4'b0001, 1'b1, 1'b0, 4'h5, 1'b1};
    tbl[8]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b1, 4'hA, 1'b1};
    tbl[9]  = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'hA, 1'b1};
    tbl[10] = '{4'b0100, 16'h0500, 16'h0700, 1'b0, 4'b0100, 1'b1, 1'b0, 4'hA, 1'b1};
    tbl[11] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'hA, 1'b1};
    tbl[12] = tbl[11];
    tbl[13] = tbl[11];
    tbl[14] = tbl[11];
    tbl[15] = tbl[11];
    tbl[16] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'hA, 1'b1};
    tbl[17] = '{4'b1000, 16'h0000, 16'h3000, 1'b0, 4'b1000, 1'b1, 1'b0, 4'hA, 1'b1};
    tbl[18] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b1, 4'h3, 1'b1};
    tbl[19] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h3, 1'b1};

    // Reset state
    do_reset();
    #1;
    check_outs("reset", 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);

    // Delay 4, zero delay, cancel at count expiry, cancel in IDLE/FIRE
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].req, tbl[i].dly, tbl[i].val, tbl[i].cancel);
      check_outs($sformatf("vec%0d", i), tbl[i].grant, tbl[i].busy, tbl[i].fire,
                 tbl[i].vout, tbl[i].valid);
    end

    // Capture semantics: value changed the cycle after grant must not commit
    drive(4'b0100, 16'h0300, 16'h0300, 1'b0);
    check("capture.grant", 32'(bus.grant), 32'(4'b0100));
    fire_seen = 0;
    steps = 0;
    while (fire_seen == 0 && steps < 20) begin
      drive(4'b0000, 16'h0000, 16'h0C00, 1'b0);
      steps++;
      if (bus.event_fire) fire_seen = 1;
    end
    check("capture.fire_latency", 32'(steps), 32'd4);
    check("capture.value_out", 32'(bus.value_out), 32'h3);

    // Round robin with all requesters active, D=1
    do_reset();
    mask = 4'b1111;
    for (int c = 0; c < 60 && rr_order.size() < 5; c++) begin
      drive(mask, 16'h1111, 16'h4321, 1'b0);
      if (bus.grant != '0) begin
        check("rr.onehot", 32'($onehot(bus.grant)), 32'd1);
        for (int i = 0; i < NREQ; i++) if (bus.grant[i]) rr_order.push_back(i);
        rr_time.push_back(c);
        mask = mask & ~bus.grant;
        if (mask == '0) mask = 4'b1111;
      end
    end
    check("rr.count", 32'(rr_order.size()), 32'd5);
    for (int i = 0; i < rr_order.size() && i < 5; i++) begin
      check($sformatf("rr.order%0d", i), 32'(rr_order[i]), 32'(exp_order[i]));
      if (i > 0) check($sformatf("rr.spacing%0d", i), 32'(rr_time[i] - rr_time[i-1]), 32'd4);
    end

    // Reset in the middle of ARM
    repeat (4) drive(4'b0000, 16'h0000, 16'h0000, 1'b0);
    check("midrst.pre_valid", 32'(bus.value_valid), 32'd1);
    drive(4'b0010, 16'h0060, 16'h00E0, 1'b0);
    check("midrst.grant", 32'(bus.grant), 32'(4'b0010));
    repeat (2) drive(4'b0000, 16'h0000, 16'h0000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("midrst.async", 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst.nofire%0d", i), 32'(bus.event_fire), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(4'b1001, 16'h0000, 16'h7001, 1'b0);
    check("midrst.prio_grant", 32'(bus.grant), 32'(4'b0001));
    drive(4'b0000, 16'h0000, 16'h0000, 1'b0);
    check_outs("midrst.fire", 4'b0000, 1'b1, 1'b1, 4'h1, 1'b1);

    // Randomized traffic against the reference model
    do_reset();
    m_last = NREQ - 1; m_armed = 0; m_fire_at = -1; m_idle_from = 0;
    m_cap = '0; m_val = '0; m_valid = 0;
    for (int n = 0; n < 500; n++) begin
      r_req = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) r_dly[i*DLYW +: DLYW] = DLYW'($urandom_range(0, 5));
      r_val = NREQ*DW'($urandom);
      r_can = ($urandom_range(0, 7) == 0);
      e_grant = '0;
      e_fire  = 0;
      if (m_armed && r_can && n < m_fire_at) begin
        m_armed = 0;
        m_idle_from = n + 1;
      end else if (m_armed && n + 1 == m_fire_at) begin
        e_fire = 1;
        m_val = m_cap;
        m_valid = 1;
        m_armed = 0;
      end else if (!m_armed && n >= m_idle_from && r_req != '0) begin
        m_found = 0;
        m_sel = 0;
        for (int o = 1; o <= NREQ; o++) begin
          if (!m_found && r_req[(m_last + o) % NREQ]) begin
            m_found = 1;
            m_sel = (m_last + o) % NREQ;
          end
        end
        e_grant[m_sel] = 1'b1;
        m_last = m_sel;
        m_cap = r_val[m_sel*DW +: DW];
        m_fire_at = n + 2 + int'(r_dly[m_sel*DLYW +: DLYW]);
        m_idle_from = m_fire_at + 1;
        m_armed = 1;
      end
      drive(r_req, r_dly, r_val, r_can);
      check_outs($sformatf("rand%0d", n), e_grant, m_armed || e_fire, e_fire, m_val, m_valid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/event_assign_sched.md
Name: event_assign_sched

Overview:
- Round-robin scheduler for a shared deferred-assignment resource, i.e. the hardware form of "target = @event value".
- Each requester posts a value and a delay.
- The scheduler grants one requester, captures its value at grant time, counts the delay and then fires a one-cycle event. On that event the captured value is committed to a shared target register.
- Sits between multiple testbench/stimulus agents and a single event-driven target register.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 4, width of the assigned value
- DLYW, 4, width of the per-request delay field (cycles)

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request level
- req_delay  input  NREQ*DLYW  packed delays; requester i uses bits [i*DLYW +: DLYW]
- req_value  input  NREQ*DW  packed values; requester i uses bits [i*DW +: DW]
- cancel  input  1  abort the armed event
- grant  output  NREQ  one-hot grant, one-cycle pulse
- busy  output  1  high while in ARM or FIRE
- event_fire  output  1  one-cycle event pulse
- value_out  output  DW  committed target register
- value_valid  output  1  sticky; set by the first fire since reset

Behaviour:
- Reset (async, reset_n=0): state=IDLE; grant=0, busy=0, event_fire=0, value_out=0, value_valid=0; round-robin pointer last=NREQ-1, so req[0] has top priority first; counter and capture register cleared.
- All outputs are registered.
- FSM states: IDLE, ARM, FIRE.
- IDLE:
  - If req!=0, select the first asserted index scanning last+1, last+2, ... mod NREQ.
  - On that edge: grant<=onehot(sel), cap<=req_value[sel], cnt<=req_delay[sel], last<=sel, state<=ARM.
  - If req==0, stay in IDLE.
- Capture semantics: the value is sampled at grant. Later changes to req_value do not affect the committed value.
- ARM:
  - grant returns to 0 after its one cycle.
  - cancel=1: state<=IDLE; no fire; value_out and value_valid unchanged. cancel has priority over cnt==0.
  - else cnt==0: state<=FIRE, event_fire<=1, value_out<=cap, value_valid<=1.
  - else cnt<=cnt-1.
- FIRE: event_fire<=0, state<=IDLE. cancel is ignored in FIRE.
- Latency: with grant high in cycle k, event_fire and the new value_out appear in cycle k+D+1. D=0 gives fire in cycle k+1.
- busy: high in every ARM and FIRE cycle, low in IDLE.
- Spacing: the next grant can come no earlier than the cycle after FIRE, so back-to-back period = D+3 cycles.
- Requester rules: hold req until grant is seen, then drop it. A req still high in IDLE is granted again under round-robin order.
- cancel in IDLE has no effect.
- req changes during ARM/FIRE are ignored.
- The pointer wraps NREQ-1 -> 0.
- Reset mid-ARM: no fire, all outputs cleared, pointer back to NREQ-1.

Test Plan:
- Reset check: after reset_n 0->1, value_out=0, value_valid=0, busy=0. Then req[1]=1, delay=4, value=4'h5 -> grant=4'b0010 in cycle k, event_fire only in k+5, value_out=4'h5 from k+5, value_valid=1.
- Zero delay: req[0], delay=0, value=4'hA -> event_fire in k+1, value_out=4'hA; busy high exactly 2 cycles.
- Capture semantics: req[2], delay=3, value=4'h3; change req_value[2] to 4'hC the cycle after grant -> committed value_out=4'h3.
- Round robin: req=4'b1111 held, each requester dropping req after its own grant -> grant order 0,1,2,3,0; grants spaced D+3 cycles.
- Cancel: arm with delay=5, assert cancel at the cycle where cnt==0 -> no event_fire, value_out keeps its previous value, state IDLE next cycle, new grant possible.
- Reset mid-ARM: arm with delay=6, pull reset_n low 2 cycles after grant -> outputs cleared immediately, no event_fire. After release, req[3] and req[0] together -> req[0] is granted first.
